// File: rtl/rssb_pkg.sv
// Shared types and reserved-address constants for the RSSB core.
package rssb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_EXEC,
    ST_WB,
    ST_HALT
  } state_t;

  // Memory-mapped register addresses for operand access; RAM starts after them.
  localparam int ADDR_PC   = 0;
  localparam int ADDR_ACC  = 1;
  localparam int ADDR_ZERO = 2;
  localparam int ADDR_IN   = 3;
  localparam int ADDR_OUT  = 4;
  localparam int PC_START  = 5;

endpackage

// File: rtl/rssb_mem.sv
// Program/data RAM: one synchronous write port, one combinational read port.
module rssb_mem #(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 32,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write on the clock edge; contents survive reset so a loaded program persists.
  // NOTE: the array has no reset term -- a reset here would turn it into a flop bank instead of RAM.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/rssb_core.sv
// Single-instruction RSSB core: reverse-subtract, skip-if-negative, with
// program-load port, start/halt control and memory-mapped PC/ACC/ZERO/IN/OUT.
module rssb_core
  import rssb_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 32,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [WIDTH-1:0]  load_data,
  input  logic              in_valid,
  input  logic [WIDTH-1:0]  in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [WIDTH-1:0]  out_data,
  input  logic              out_ready,
  output logic              busy,
  output logic              halted,
  output logic [ADDR_W-1:0] opc,
  output logic [WIDTH-1:0]  oacc
);

  localparam logic [ADDR_W-1:0] A_PC    = ADDR_W'(ADDR_PC);
  localparam logic [ADDR_W-1:0] A_ACC   = ADDR_W'(ADDR_ACC);
  localparam logic [ADDR_W-1:0] A_ZERO  = ADDR_W'(ADDR_ZERO);
  localparam logic [ADDR_W-1:0] A_IN    = ADDR_W'(ADDR_IN);
  localparam logic [ADDR_W-1:0] A_OUT   = ADDR_W'(ADDR_OUT);
  localparam logic [ADDR_W-1:0] A_START = ADDR_W'(PC_START);

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] op;
  logic [WIDTH-1:0]  acc;
  logic [WIDTH-1:0]  res;
  logic              neg;

  logic              idle_like;
  logic              load_we;
  logic              exec_go;
  logic              wb_commit;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_waddr;
  logic [WIDTH-1:0]  ram_wdata;
  logic [ADDR_W-1:0] ram_raddr;
  logic [WIDTH-1:0]  ram_rdata;
  logic [WIDTH-1:0]  operand;
  logic [WIDTH-1:0]  diff;
  logic [ADDR_W-1:0] pc_seq;

  assign idle_like = (state == ST_IDLE) || (state == ST_HALT);
  assign load_we   = idle_like && load_en;
  assign exec_go   = (state == ST_EXEC) && !((op == A_IN) && !in_valid);
  assign wb_commit = (state == ST_WB) && !((op == A_OUT) && !out_ready);

  // Load port and write-back share the RAM write port; they never overlap in time.
  assign ram_we    = load_we || (wb_commit && (op >= A_START));
  assign ram_waddr = load_we ? load_addr : op;
  assign ram_wdata = load_we ? load_data : res;
  // Fetch reads at pc; otherwise the read port serves the operand.
  assign ram_raddr = (state == ST_FETCH) ? pc : op;

  rssb_mem #(
    .WIDTH  (WIDTH),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_mem (
    .clk   (clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (ram_wdata),
    .raddr (ram_raddr),
    .rdata (ram_rdata)
  );

  // Operand read through the address map; low addresses shadow RAM.
  always_comb begin
    // NOTE: default assignment first so every path drives operand and no latch is inferred.
    operand = ram_rdata;
    case (op)
      A_PC:    operand = WIDTH'(pc);
      A_ACC:   operand = acc;
      A_ZERO:  operand = '0;
      A_IN:    operand = in_data;
      A_OUT:   operand = '0;
      default: operand = ram_rdata;
    endcase
  end

  assign diff     = operand - acc;
  assign pc_seq   = pc + (neg ? ADDR_W'(2) : ADDR_W'(1));
  assign in_ready = (state == ST_EXEC) && (op == A_IN) && in_valid;
  assign busy     = !idle_like;
  assign halted   = (state == ST_HALT);
  assign opc      = pc;
  assign oacc     = acc;

  // Control FSM with architectural state and the registered output port.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_IDLE;
      pc        <= A_START;
      acc       <= '0;
      op        <= '0;
      res       <= '0;
      neg       <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every branch sees pre-edge values.
      case (state)
        ST_IDLE, ST_HALT: begin
          if (start) begin
            state <= ST_FETCH;
            pc    <= A_START;
            acc   <= '0;
          end
        end
        ST_FETCH: begin
          if (&ram_rdata) begin
            state <= ST_HALT;
          end else begin
            op    <= ram_rdata[ADDR_W-1:0];
            state <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (exec_go) begin
            res   <= diff;
            neg   <= diff[WIDTH-1];
            state <= ST_WB;
            if (op == A_OUT) begin
              out_valid <= 1'b1;
              out_data  <= diff;
            end
          end
        end
        ST_WB: begin
          if (wb_commit) begin
            acc       <= res;
            pc        <= (op == A_PC) ? res[ADDR_W-1:0] : pc_seq;
            out_valid <= 1'b0;
            state     <= ST_FETCH;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rssb_core.sv
// Directed testbench for rssb_core with expected-result scoreboards.
module tb_rssb_core;

  localparam int WIDTH  = 8;
  localparam int DEPTH  = 32;
  localparam int ADDR_W = 5;

  logic              clk;
  logic              rst;
  logic              start;
  logic              load_en;
  logic [ADDR_W-1:0] load_addr;
  logic [WIDTH-1:0]  load_data;
  logic              in_valid;
  logic [WIDTH-1:0]  in_data;
  logic              in_ready;
  logic              out_valid;
  logic [WIDTH-1:0]  out_data;
  logic              out_ready;
  logic              busy;
  logic              halted;
  logic [ADDR_W-1:0] opc;
  logic [WIDTH-1:0]  oacc;

  int checks = 0;
  int failures = 0;
  int in_ready_pulses = 0;

  typedef struct {
    string tag;
    int    pc;
    int    acc;
  } halt_exp_t;

  halt_exp_t halt_q[$];
  int        out_q[$];

  rssb_core #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .load_en   (load_en),
    .load_addr (load_addr),
    .load_data (load_data),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .busy      (busy),
    .halted    (halted),
    .opc       (opc),
    .oacc      (oacc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (in_ready) in_ready_pulses++;
  end

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input int a, input int d);
    load_en   = 1'b1;
    load_addr = ADDR_W'(a);
    load_data = WIDTH'(d);
    tick();
    load_en = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  function automatic int ram(input int a);
    return int'(u_dut.u_mem.mem[a]);
  endfunction

  // Wait (bounded) for HALT, then pop and compare the expected final pc/acc.
  task automatic run_to_halt(input int budget);
    halt_exp_t e;
    int n = 0;
    while (!halted && n < budget) begin
      tick();
      n++;
    end
    e = halt_q.pop_front();
    check({e.tag, "_halted"}, 32'(halted), 1);
    check({e.tag, "_pc"}, 32'(opc), e.pc);
    check({e.tag, "_acc"}, 32'(oacc), e.acc);
    check({e.tag, "_busy"}, 32'(busy), 0);
  endtask

  task automatic wait_out_valid(input string tag, input int budget);
    int n = 0;
    while (!out_valid && n < budget) begin
      tick();
      n++;
    end
    check({tag, "_out_valid_seen"}, 32'(out_valid), 1);
  endtask

  initial begin
    int exp_out;
    int n;

    rst       = 1'b0;
    start     = 1'b0;
    load_en   = 1'b0;
    load_addr = '0;
    load_data = '0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    #12;

    // Reset state
    check("rst_pc", 32'(opc), 5);
    check("rst_acc", 32'(oacc), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_halted", 32'(halted), 0);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_data", 32'(out_data), 0);
    check("rst_in_ready", 32'(in_ready), 0);
    @(negedge clk);
    rst = 1'b1;
    tick();

    // Basic execute and halt, exact latency
    load(5, 10);
    load(6, 'hFF);
    load(10, 7);
    halt_q.push_back('{"t2", 6, 7});
    pulse_start();
    check("t2_busy", 32'(busy), 1);
    tick();
    tick();
    tick();
    check("t2_not_halted_edge3", 32'(halted), 0);
    check("t2_pc_edge3", 32'(opc), 6);
    tick();
    check("t2_halted_edge4", 32'(halted), 1);
    run_to_halt(1);
    check("t2_ram10", ram(10), 7);

    // Skip on negative; load and start in the same cycle
    load(6, 11);
    load(7, 'hFF);
    load(8, 'hFF);
    load(10, 7);
    load(11, 3);
    load_en   = 1'b1;
    load_addr = 5'd5;
    load_data = 8'd10;
    start     = 1'b1;
    tick();
    load_en = 1'b0;
    start   = 1'b0;
    halt_q.push_back('{"t3", 8, 'hFC});
    run_to_halt(40);
    check("t3_ram11", ram(11), 'hFC);
    check("t3_ram10", ram(10), 7);

    // Input stall
    load(5, 3);
    load(6, 'hFF);
    halt_q.push_back('{"t4", 6, 'h20});
    in_ready_pulses = 0;
    pulse_start();
    tick();
    check("t4_stall0_in_ready", 32'(in_ready), 0);
    tick();
    tick();
    check("t4_stall2_in_ready", 32'(in_ready), 0);
    check("t4_stall2_busy", 32'(busy), 1);
    check("t4_stall2_pc", 32'(opc), 5);
    in_valid = 1'b1;
    in_data  = 8'h20;
    #1;
    check("t4_in_ready_high", 32'(in_ready), 1);
    tick();
    check("t4_wb_in_ready", 32'(in_ready), 0);
    run_to_halt(20);
    check("t4_in_ready_pulses", in_ready_pulses, 1);
    in_valid = 1'b0;

    // Output handshake; start/load while busy are ignored
    in_valid  = 1'b1;
    in_data   = 8'h20;
    out_ready = 1'b0;
    load(5, 3);
    load(6, 4);
    load(7, 'hFF);
    load(8, 'hFF);
    halt_q.push_back('{"t5", 8, 'hE0});
    out_q.push_back('hE0);
    pulse_start();
    wait_out_valid("t5", 20);
    exp_out = out_q.pop_front();
    for (int i = 0; i < 3; i++) begin
      check($sformatf("t5_out_valid_%0d", i), 32'(out_valid), 1);
      check($sformatf("t5_out_data_%0d", i), 32'(out_data), exp_out);
      if (i == 1) begin
        start     = 1'b1;
        load_en   = 1'b1;
        load_addr = 5'd8;
        load_data = 8'h00;
      end
      if (i == 2) begin
        start     = 1'b0;
        load_en   = 1'b0;
        out_ready = 1'b1;
      end
      tick();
    end
    check("t5_out_valid_drop", 32'(out_valid), 0);
    check("t5_pc_skip", 32'(opc), 8);
    out_ready = 1'b0;
    in_valid  = 1'b0;
    run_to_halt(20);
    check("t5_ram8_kept", ram(8), 'hFF);

    // PC write landing at 10 after reaching pc=5 with acc=0xFB
    load(0, 2);
    load(1, 2);
    load(2, 2);
    load(3, 21);
    load(21, 'hFB);
    load(5, 0);
    load(10, 'hFF);
    halt_q.push_back('{"t6a", 10, 'h0A});
    pulse_start();
    run_to_halt(80);

    // PC write to 31, then wrap to 0
    load(5, 22);
    load(22, 'hE8);
    load(7, 0);
    load(31, 20);
    load(20, 'h28);
    load(0, 'hFF);
    halt_q.push_back('{"t6b", 0, 9});
    pulse_start();
    n = 0;
    while (opc != 5'd31 && n < 40) begin
      tick();
      n++;
    end
    check("t6b_reached_pc31", 32'(opc), 31);
    run_to_halt(20);
    check("t6b_ram20", ram(20), 9);

    // Reset mid-run while an output is pending
    load(25, 'h55);
    load(5, 25);
    load(6, 4);
    out_q.push_back('hAB);
    pulse_start();
    wait_out_valid("t1b", 20);
    exp_out = out_q.pop_front();
    check("t1b_out_data", 32'(out_data), exp_out);
    check("t1b_pc_before", 32'(opc), 6);
    #2;
    rst = 1'b0;
    #1;
    check("t1b_pc", 32'(opc), 5);
    check("t1b_acc", 32'(oacc), 0);
    check("t1b_busy", 32'(busy), 0);
    check("t1b_halted", 32'(halted), 0);
    check("t1b_out_valid", 32'(out_valid), 0);
    check("t1b_out_data_rst", 32'(out_data), 0);
    check("t1b_in_ready", 32'(in_ready), 0);
    @(negedge clk);
    rst = 1'b1;
    tick();
    check("t1b_ram25", ram(25), 'h55);
    check("t1b_ram5", ram(5), 25);
    check("t1b_ram6", ram(6), 4);
    check("t1b_idle", 32'(busy), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rssb_core.md
# rssb_core

Parametrised successor to the 8-bit RSSB (reverse-subtract, skip-if-negative) processor. It adds:
- configurable data width and memory depth;
- an external program-load port and a start/halt handshake;
- a halt instruction;
- memory-mapped PC, ACC, zero, input and output registers with valid/ready handshakes.

It sits at the top of the RSSB design as the complete single-instruction core.

## Interface
- WIDTH, 8, data/instruction word width (≥ ADDR_W)
- DEPTH, 32, memory words; power of two, ≥ 8
- ADDR_W, $clog2(DEPTH), address width (derived)

- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- start  in  1  begin execution; honoured in IDLE/HALT only
- load_en  in  1  write load_data to RAM[load_addr]; honoured in IDLE/HALT only
- load_addr  in  ADDR_W  program-load address
- load_data  in  WIDTH  program-load data
- in_valid  in  1  input word available
- in_data  in  WIDTH  input word
- in_ready  out  1  input word consumed this cycle
- out_valid  out  1  output word presented
- out_data  out  WIDTH  output word
- out_ready  in  1  sink accepts output word
- busy  out  1  state ∉ {IDLE, HALT}
- halted  out  1  state == HALT
- opc  out  ADDR_W  program counter
- oacc  out  WIDTH  accumulator

## Operation
- Instruction = one word; operand address a = word[ADDR_W-1:0].
- Word == all-ones (WIDTH bits) is HALT.
- Execute: v = read(a); r = v − acc (mod 2^WIDTH); neg = r[WIDTH-1]; acc ← r; write(a, r).
- Next PC: pc+2 if neg, else pc+1, modulo DEPTH (wrap-around).
- Address map for operand read/write (instruction fetch always reads raw RAM):
  - 0 = PC: read returns pc; write sets pc ← r, and no increment/skip follows.
  - 1 = ACC: read returns acc; write is redundant.
  - 2 = ZERO: reads 0; write discarded.
  - 3 = IN: read waits for in_valid, returns in_data, pulses in_ready one cycle; write discarded.
  - 4 = OUT: reads 0; write presents r on out_data with out_valid and holds until out_ready.
  - ≥ 5: RAM.
- RAM locations 0..4 exist and are loadable but are reachable only via fetch.
- FSM states: IDLE, FETCH, EXEC, WB, HALT.
  - IDLE/HALT, start=1 → FETCH, with pc ← 5 and acc ← 0.
  - FETCH → HALT if word is all-ones; otherwise op ← a, → EXEC.
  - EXEC: if a==3 and !in_valid, stay. Otherwise latch r and neg, → WB.
  - WB: if a==4 and !out_ready, stay with out_valid=1. Otherwise commit acc, RAM/PC and next pc, → FETCH.
- start while busy is ignored.
- load_en while busy is ignored.
- In IDLE/HALT, start and load_en in the same cycle: the load is performed and execution starts.

## Timing
- Reset (rst=0, immediate) sets:
  - state=IDLE, pc=5, acc=0;
  - in_ready=0, out_valid=0, out_data=0;
  - busy=0, halted=0.
- RAM is not reset.
- RAM: combinational read, synchronous write.
- Un-stalled instruction = 3 cycles (FETCH, EXEC, WB).
- in_ready is asserted combinationally in the EXEC cycle where a==3 and in_valid=1.
- out_valid is asserted in every WB cycle with a==4. out_data is stable until the handshake completes. Transfer happens on the edge where out_valid and out_ready are both 1.
- halted rises on the edge that completes FETCH of a HALT word.
- opc and oacc remain readable while halted.

## Structure
- Package rssb_pkg holds:
  - state enum state_t;
  - reserved-address constants ADDR_PC=0, ADDR_ACC=1, ADDR_ZERO=2, ADDR_IN=3, ADDR_OUT=4, PC_START=5.
- Sub-module rssb_mem (DEPTH×WIDTH, sync write, async read).
  - Write port is muxed between the load port and WB.

## Test plan
1. Reset and idle:
   - Stimulus: assert rst=0 mid-run, then release.
   - Response: pc=5, acc=0, busy=0, halted=0, out_valid=0, in_ready=0. Preloaded RAM contents are unchanged.
2. Basic execute and halt (WIDTH=8, DEPTH=32):
   - Stimulus: load RAM[5]=10, RAM[6]=0xFF, RAM[10]=7; pulse start.
   - Response: RAM[10]=7, acc=7, halted=1 with pc=6, four edges after the start-sampling edge.
3. Skip on negative:
   - Stimulus: load RAM[5]=10, RAM[6]=11, RAM[7]=0xFF, RAM[8]=0xFF, RAM[10]=7, RAM[11]=3; pulse start.
   - Response: RAM[11]=0xFC, acc=0xFC, halted with pc=8 (RAM[7] skipped).
4. Input stall:
   - Stimulus: program RAM[5]=3, RAM[6]=0xFF; raise in_valid with in_data=0x20 three cycles into EXEC.
   - Response: EXEC is held 3 cycles; in_ready pulses exactly once; acc=0x20.
5. Output handshake:
   - Stimulus: with acc=0x20, execute word 4; hold out_ready=0 for 2 cycles.
   - Response: out_valid=1 with out_data=0xE0 for 3 cycles, then drops; pc skips by 2.
6. PC write and wrap:
   - Stimulus A: RAM[5]=0 executed with acc=0xFB.
   - Response A: pc=10, acc=10.
   - Stimulus B: instruction at pc=31 with a non-negative result.
   - Response B: next fetch from pc=0.
